instr_mem_resp: RTL and testbench
=================================

Name: instr_mem_resp

Overview:
- Responder end of the instruction-fetch read interface: accepts the fetch unit's per-cycle read requests (req + byte address) and returns 32-bit instruction words after a fixed, parameterised latency.
- Holds a word-addressed instruction array, loaded through a separate program-load write port by the bench or boot logic.
- Out-of-range or misaligned fetches return a NOP and raise an error flag, so the core never executes garbage.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, minimum 4.
- LATENCY, 1, cycles from request sample edge to response; legal range 1..4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.
- NOP_INSTR, 32'h0000_0013, word returned on erroneous fetch (addi x0,x0,0).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- mem_req_i  input  1  read request, sampled every rising edge.
- mem_addr_i  input  32  byte address of requested instruction, valid when mem_req_i=1.
- mem_rd_data_o  output  32  returned instruction word.
- mem_rd_valid_o  output  1  one-cycle pulse per response; mem_rd_data_o is valid in this cycle.
- mem_err_o  output  1  qualifies the response: 1 = misaligned or out-of-range fetch.
- prog_we_i  input  1  program-load write enable.
- prog_addr_i  input  32  byte address for the program-load write.
- prog_data_i  input  32  write data.
- prog_err_o  output  1  one-cycle pulse: the program-load write was rejected.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, reset_n).
  - Reset asserted drives mem_rd_data_o=0, mem_rd_valid_o=0, mem_err_o=0, prog_err_o=0, and clears every request-pipeline stage.
  - Array contents are not reset; they persist across reset.
- Address decode, shared by read and write:
  - off = addr - BASE_ADDR, computed as 32-bit unsigned.
  - idx = off[31:2].
  - aligned = (addr[1:0]==0).
  - in_range = (addr >= BASE_ADDR) && (idx < DEPTH_WORDS).
  - ok = aligned && in_range.
- Read path:
  - On each rising edge with mem_req_i=1, the request enters stage 1 of a LATENCY-deep pipeline.
  - Each stage holds valid, err and data. Data is read from the array at the sample edge: the array word if ok, else NOP_INSTR; err = !ok.
  - Stage LATENCY drives the outputs: mem_rd_valid_o = stage valid, and mem_err_o is driven likewise.
  - mem_rd_data_o updates only when a valid response leaves the pipeline. It holds its last value otherwise and is never 'x after reset.
  - Response for a request sampled at edge N appears in the cycle after edge N+LATENCY-1, i.e. LATENCY=1 means data is valid the cycle after sampling.
  - Full throughput: one request per cycle, responses in order, no back-pressure and no stall input.
  - mem_req_i=0 inserts a bubble. mem_addr_i is ignored when req=0.
- Program-load path:
  - On a rising edge with prog_we_i=1 and ok(prog_addr_i), array[idx] <= prog_data_i.
  - If not ok, no write occurs and prog_err_o pulses high for one cycle after that edge. prog_err_o is 0 otherwise.
- Simultaneous read and write of the same word on the same edge: read-before-write. The response carries the old word; the next request sees the new word.
- Simultaneous read and write of different words: both proceed independently.
- Reset mid-operation: in-flight responses are dropped. No mem_rd_valid_o pulse may appear for requests sampled before reset assertion.
- Address wrap: BASE_ADDR > addr gives in_range=0 even though the subtraction wraps. The top word (idx = DEPTH_WORDS-1) is in range; idx = DEPTH_WORDS is not.
- Error responses consume a pipeline slot exactly like normal responses. Latency is identical.
- Illegal LATENCY, DEPTH_WORDS or BASE_ADDR values are elaboration errors.

Test Plan:
- Load and read, LATENCY=1, BASE_ADDR=0:
  - Stimulus: program words 0..3 with 32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213; then req addresses 0,4,8,12 on consecutive cycles.
  - Response: valid on 4 consecutive cycles starting one cycle after first req, data in order, err=0.
- Latency and bubbles, LATENCY=3:
  - Stimulus: req addr 0, idle one cycle, req addr 4.
  - Response: valid pulses exactly 3 cycles after each sample edge, with one non-valid cycle between them; mem_rd_data_o holds 32'h0010_0093 during the gap.
- Error fetches:
  - Stimulus: req addr 32'h2 (misaligned); req addr 4*DEPTH_WORDS = 32'h1000 (out of range); with BASE_ADDR=32'h100, req addr 32'h0FC.
  - Response: each returns data 32'h0000_0013 with mem_err_o=1. Also req addr 32'hFFC (last word, BASE 0) -> err=0.
- Collision:
  - Stimulus: word 5 holds 32'hAAAA_AAAA; same edge: req addr 20 and prog write addr 20 data 32'h5555_5555; next cycle req addr 20.
  - Response: first response 32'hAAAA_AAAA, second 32'h5555_5555.
- Rejected program write:
  - Stimulus: prog write addr 32'h6 data 32'hDEAD_BEEF.
  - Response: prog_err_o pulses one cycle; reading words 1 and 2 afterwards shows unchanged contents.
- Reset mid-flight, LATENCY=3:
  - Stimulus: requests on 3 consecutive edges, then assert reset_n=0 asynchronously between edges before any response, release after 2 cycles.
  - Response: outputs go to 0 immediately on assertion, no valid pulse ever appears for those requests, and array contents are intact on re-read.

Source files
------------

// File: rtl/instr_mem_resp_if.sv
// Instruction-fetch read port plus program-load write port.
// The master modport is the fetch/boot side; the slave modport is the memory.
interface instr_mem_resp_if;
  logic        mem_req_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_rd_data_o;
  logic        mem_rd_valid_o;
  logic        mem_err_o;
  logic        prog_we_i;
  logic [31:0] prog_addr_i;
  logic [31:0] prog_data_i;
  logic        prog_err_o;

  modport master (
    output mem_req_i, mem_addr_i, prog_we_i, prog_addr_i, prog_data_i,
    input  mem_rd_data_o, mem_rd_valid_o, mem_err_o, prog_err_o
  );

  modport slave (
    input  mem_req_i, mem_addr_i, prog_we_i, prog_addr_i, prog_data_i,
    output mem_rd_data_o, mem_rd_valid_o, mem_err_o, prog_err_o
  );
endinterface

// File: rtl/instr_mem_resp.sv
// Instruction memory responder: fixed-latency in-order fetch responses with a
// NOP/error reply for misaligned or out-of-range addresses, plus a program-load port.
module instr_mem_resp #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input logic              clk,
  input logic              reset_n,
  instr_mem_resp_if.slave  bus
);

  localparam int          AW     = $clog2(DEPTH_WORDS);
  localparam logic [29:0] BASE_W = BASE_ADDR[31:2];

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("instr_mem_resp: LATENCY must be in 1..4");
  end
  if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("instr_mem_resp: DEPTH_WORDS must be a power of two, at least 4");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("instr_mem_resp: BASE_ADDR must be word-aligned");
  end

  // BASE_ADDR is aligned, so the word offset can be formed from bits [31:2] alone;
  // the explicit addr >= BASE_ADDR term rejects addresses that wrap below the base.
  function automatic logic addr_ok(input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2] - BASE_W;
    return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && (w < 30'(DEPTH_WORDS));
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2] - BASE_W;
    return w[AW-1:0];
  endfunction

  logic [31:0]        mem [DEPTH_WORDS];
  logic               rd_ok;
  logic               wr_ok;
  logic [AW-1:0]      rd_idx;
  logic [AW-1:0]      wr_idx;
  logic [LATENCY-1:0] st_valid;
  logic [LATENCY-1:0] st_err;
  logic [31:0]        st_data [LATENCY];
  logic               prog_err;

  assign rd_ok  = addr_ok(bus.mem_addr_i);
  assign rd_idx = word_idx(bus.mem_addr_i);
  assign wr_ok  = addr_ok(bus.prog_addr_i);
  assign wr_idx = word_idx(bus.prog_addr_i);

  // Data registers only load behind a valid entry, so the last stage holds the
  // most recent response word across bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_valid <= '0;
      st_err   <= '0;
      for (int k = 0; k < LATENCY; k++) st_data[k] <= '0;
    end else begin
      st_valid[0] <= bus.mem_req_i;
      st_err[0]   <= bus.mem_req_i & ~rd_ok;
      if (bus.mem_req_i) st_data[0] <= rd_ok ? mem[rd_idx] : NOP_INSTR;
      for (int k = 1; k < LATENCY; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_err[k]   <= st_err[k-1];
        if (st_valid[k-1]) st_data[k] <= st_data[k-1];
      end
    end
  end

  // Array is deliberately not reset so a loaded program survives a core reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we_i && wr_ok) mem[wr_idx] <= bus.prog_data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prog_err <= 1'b0;
    else          prog_err <= bus.prog_we_i & ~wr_ok;
  end

  assign bus.mem_rd_valid_o = st_valid[LATENCY-1];
  assign bus.mem_err_o      = st_err[LATENCY-1];
  assign bus.mem_rd_data_o  = st_data[LATENCY-1];
  assign bus.prog_err_o     = prog_err;

endmodule

// File: tb/tb_instr_mem_resp.sv
// Scoreboard bench: three responders (latency 1, latency 3, base 0x100) share one stimulus stream.
module tb_instr_mem_resp;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pdata = '0;

  always #5 clk = ~clk;

  instr_mem_resp_if if_a ();
  instr_mem_resp_if if_c ();
  instr_mem_resp_if if_b ();

  assign if_a.mem_req_i = req;  assign if_a.mem_addr_i = addr;
  assign if_a.prog_we_i = we;   assign if_a.prog_addr_i = paddr; assign if_a.prog_data_i = pdata;
  assign if_c.mem_req_i = req;  assign if_c.mem_addr_i = addr;
  assign if_c.prog_we_i = we;   assign if_c.prog_addr_i = paddr; assign if_c.prog_data_i = pdata;
  assign if_b.mem_req_i = req;  assign if_b.mem_addr_i = addr;
  assign if_b.prog_we_i = we;   assign if_b.prog_addr_i = paddr; assign if_b.prog_data_i = pdata;

  instr_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .bus(if_a));
  instr_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h0)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .bus(if_c));
  instr_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h100)) u_base (
    .clk(clk), .reset_n(reset_n), .bus(if_b));

  typedef struct {
    logic [31:0] data;
    logic        err;
    bit          chk;
    int          edge_n;
  } exp_t;

  exp_t        sbq [3][$];
  logic [31:0] m0 [int];
  logic [31:0] mb [int];
  logic [2:0]  pe_at [int];
  int          lat_of [3]  = '{1, 3, 1};
  logic [31:0] base_of [3] = '{32'h0, 32'h0, 32'h100};
  logic [31:0] last_d [3]  = '{32'h0, 32'h0, 32'h0};
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit dec_ok(input logic [31:0] a, input logic [31:0] base);
    logic [31:0] off;
    off = a - base;
    return (a[1:0] == 2'b00) && (a >= base) && (off < 32'd4096);
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s dut%0d @cyc %0d: got %h expected %h", nm, id, cyc, act, exp);
    end
  endtask

  // Expectations are computed before the model write, giving read-before-write.
  task automatic issue(input bit r, input logic [31:0] ra, input bit w,
                       input logic [31:0] wa, input logic [31:0] wd);
    @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++) begin
      if (r) begin
        exp_t x;
        bit   ok;
        int   i;
        ok       = dec_ok(ra, base_of[id]);
        i        = int'((ra - base_of[id]) >> 2);
        x.err    = !ok;
        x.chk    = 1'b1;
        x.data   = NOP;
        x.edge_n = cyc + lat_of[id];
        if (ok) begin
          if (id == 2) begin
            if (mb.exists(i)) x.data = mb[i]; else x.chk = 1'b0;
          end else begin
            if (m0.exists(i)) x.data = m0[i]; else x.chk = 1'b0;
          end
        end
        sbq[id].push_back(x);
      end
    end
    if (w) begin
      logic [2:0] pe;
      pe = '0;
      for (int id = 0; id < 3; id++) begin
        if (dec_ok(wa, base_of[id])) begin
          if (id == 0) m0[int'((wa - base_of[id]) >> 2)] = wd;
          if (id == 2) mb[int'((wa - base_of[id]) >> 2)] = wd;
        end else begin
          pe[id] = 1'b1;
        end
      end
      pe_at[cyc + 1] = pe;
    end
    req = r; addr = ra; we = w; paddr = wa; pdata = wd;
  endtask

  task automatic rd(input logic [31:0] a);
    issue(1'b1, a, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    issue(1'b0, 32'h0, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) issue(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic mon(input int id, input logic v, input logic [31:0] d,
                     input logic e, input logic pe);
    exp_t       x;
    logic [2:0] pexp;
    pexp = pe_at.exists(cyc) ? pe_at[cyc] : 3'b000;
    if (v) begin
      if (sbq[id].size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL spurious_valid dut%0d @cyc %0d: got valid with data %h, expected no response", id, cyc, d);
      end else begin
        x = sbq[id].pop_front();
        chk("resp_edge", id, 32'(cyc), 32'(x.edge_n));
        chk("resp_err", id, 32'(e), 32'(x.err));
        if (x.chk) chk("resp_data", id, d, x.data);
      end
      last_d[id] = d;
    end else begin
      chk("hold_data", id, d, last_d[id]);
      chk("idle_err", id, 32'(e), 32'h0);
    end
    chk("prog_err", id, 32'(pe), 32'(pexp[id]));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, if_a.mem_rd_valid_o, if_a.mem_rd_data_o, if_a.mem_err_o, if_a.prog_err_o);
      mon(1, if_c.mem_rd_valid_o, if_c.mem_rd_data_o, if_c.mem_err_o, if_c.prog_err_o);
      mon(2, if_b.mem_rd_valid_o, if_b.mem_rd_data_o, if_b.mem_err_o, if_b.prog_err_o);
    end
  end

  task automatic rst_chk(input string nm);
    chk({nm, "_valid"}, 0, 32'(if_a.mem_rd_valid_o), 32'h0);
    chk({nm, "_data"},  0, if_a.mem_rd_data_o, 32'h0);
    chk({nm, "_err"},   0, 32'(if_a.mem_err_o), 32'h0);
    chk({nm, "_perr"},  0, 32'(if_a.prog_err_o), 32'h0);
    chk({nm, "_valid"}, 1, 32'(if_c.mem_rd_valid_o), 32'h0);
    chk({nm, "_data"},  1, if_c.mem_rd_data_o, 32'h0);
    chk({nm, "_err"},   1, 32'(if_c.mem_err_o), 32'h0);
    chk({nm, "_perr"},  1, 32'(if_c.prog_err_o), 32'h0);
    chk({nm, "_valid"}, 2, 32'(if_b.mem_rd_valid_o), 32'h0);
    chk({nm, "_data"},  2, if_b.mem_rd_data_o, 32'h0);
    chk({nm, "_err"},   2, 32'(if_b.mem_err_o), 32'h0);
    chk({nm, "_perr"},  2, 32'(if_b.prog_err_o), 32'h0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    rst_chk("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Program load; addresses below 0x100 are rejected by the base-0x100 instance.
    wr(32'h0000, 32'h0010_0093);
    wr(32'h0004, 32'h0020_0113);
    wr(32'h0008, 32'h0030_0193);
    wr(32'h000C, 32'h0040_0213);
    wr(32'h0014, 32'hAAAA_AAAA);
    wr(32'h00FC, 32'h0BAD_F00D);
    wr(32'h0FFC, 32'h1234_5678);
    idle(2);

    // Back-to-back reads
    rd(32'h0); rd(32'h4); rd(32'h8); rd(32'hC);
    idle(4);

    // Bubble between two reads
    rd(32'h0); idle(1); rd(32'h4);
    idle(5);

    // Misaligned, past the top, below the base, last word
    rd(32'h2); rd(32'h1000); rd(32'h0FC); rd(32'hFFC);
    idle(4);

    // Same-word read and write on one edge, then re-read
    issue(1'b1, 32'h14, 1'b1, 32'h14, 32'h5555_5555);
    rd(32'h14);
    idle(4);

    // Misaligned write is dropped
    wr(32'h6, 32'hDEAD_BEEF);
    rd(32'h4); rd(32'h8);
    idle(4);

    // Reset with requests in flight
    rd(32'h0); rd(32'h4); rd(32'h8);
    #1;
    reset_n = 1'b0;
    for (int id = 0; id < 3; id++) begin
      sbq[id].delete();
      last_d[id] = '0;
    end
    #1;
    rst_chk("midrst");
    req = 1'b0;
    we  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(3);
    rd(32'h0); rd(32'h4); rd(32'h8); rd(32'hC);
    idle(6);

    for (int id = 0; id < 3; id++) chk("drain", id, 32'(sbq[id].size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
